idex_hazard_stage: RTL
======================

// Module: idex_hazard_stage
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection and bubble insertion.
//  Captures decoded operands/control from ID; drives IDEX_* fields consumed by EX and the forwarding unit.
//  Stalls PC and IF/ID on load-use, kills the EX-bound instruction on branch/jump flush,
//  and freezes on mem_busy. Counts inserted load-use bubbles for performance debug.
// PARAMETERS
//  DATA_W  32  operand/immediate/PC width
//  CTRL_W  16  width of opaque EX/MEM/WB control bundle (ALUOp, ALUSrc, MemWrite, MemtoReg, ...)
//  CNT_W   16  width of load-use bubble counter
// PORTS
//  clk            in   1       single clock, all state on rising edge
//  reset          in   1       synchronous, active-low (reset==0 resets on the clock edge)
//  id_valid       in   1       ID holds a real instruction
//  IFID_Reg_Rs    in   5       rs of instruction in ID
//  IFID_Reg_Rt    in   5       rt of instruction in ID
//  id_rd          in   5       destination reg after RegDst mux
//  id_data1/2     in   DATA_W  register-file read data
//  id_imm         in   DATA_W  extended immediate
//  id_pc_plus4    in   DATA_W  PC+4 of ID instruction
//  id_ctrl        in   CTRL_W  control bundle
//  id_MemRead     in   1       ID instruction is a load
//  id_RegWrite    in   1       ID instruction writes a register
//  ex_flush       in   1       branch/jump resolved taken; kill ID instruction entering EX
//  mem_busy       in   1       data memory not ready; freeze this stage
//  IDEX_Reg_Rs/Rt/Rd out 5     registered fields (to forwarding + EX)
//  IDEX_Data1/2, IDEX_Imm, IDEX_PC_plus4  out DATA_W  registered operands
//  IDEX_Ctrl      out  CTRL_W  registered control bundle
//  IDEX_MemRead, IDEX_RegWrite, IDEX_Valid  out 1
//  PC_Write       out  1       comb; 0 holds PC
//  IFID_Write     out  1       comb; 0 holds IF/ID register
//  bubble_cnt     out  CNT_W   load-use bubbles inserted, saturating
//  state          out  2       00 RUN, 01 BUBBLE, 10 HOLD
// BEHAVIOUR
//  Reset (reset==0 at edge): all IDEX_* = 0, IDEX_Valid=0, bubble_cnt=0, state=RUN. Overrides every input.
//  hazard (comb) = id_valid & IDEX_Valid & IDEX_MemRead & (IDEX_Reg_Rd!=0)
//                  & (IDEX_Reg_Rd==IFID_Reg_Rs | IDEX_Reg_Rd==IFID_Reg_Rt). Rd holds load target (rt).
//  Edge priority (reset excluded): ex_flush > mem_busy > hazard > load.
//   flush: load bubble (all IDEX_* = 0, Valid=0); state->RUN; counter unchanged.
//   mem_busy: hold all IDEX_* ; state->HOLD.
//   hazard: load bubble; bubble_cnt+1 (saturate at all-ones); state->BUBBLE.
//   load: IDEX_* <= id_* ; IDEX_Valid <= id_valid; state->RUN.
//  Bubble: IDEX_Ctrl=0, MemRead=0, RegWrite=0, Reg_Rs/Rt/Rd=0 so forwarding never matches it.
//  PC_Write = IFID_Write = ~(mem_busy | (hazard & ~ex_flush)); flush never stalls fetch.
//  Latency: one cycle ID->IDEX. Load-use costs exactly one bubble; next cycle IDEX holds a bubble
//   so hazard deasserts and the stalled instruction loads (forwarding supplies the load data from MEM/WB).
//  BUBBLE lasts one cycle, then RUN or HOLD per inputs. HOLD exits when mem_busy=0 (hazard re-evaluated then).
//  Hazard during mem_busy: no bubble, no count; re-evaluated when busy clears.
//  id_valid=0: never hazard; loads Valid=0 with captured fields (EX must gate on IDEX_Valid).
// TESTING
//  1 reset=0 one edge with ids driven -> all IDEX_* 0, bubble_cnt 0, state 00; PC_Write=1.
//  2 lw $8 in IDEX, ID add rs=8 -> PC_Write=IFID_Write=0, next edge IDEX bubble, cnt 1, state 01;
//    following edge add loaded (IDEX_Reg_Rs=8), state 00.
//  3 lw $0 in IDEX, ID uses rs=0 -> no stall, cnt stays 0.
//  4 hazard and ex_flush same cycle -> bubble loaded, PC_Write=1, cnt unchanged, state 00.
//  5 mem_busy=1 three cycles with hazard present -> IDEX frozen, state 10, cnt 0; busy clears -> bubble, cnt 1.
//  6 force 65535 bubbles then one more -> bubble_cnt stays 16'hFFFF; reset=0 mid-BUBBLE -> state 00, cnt 0.

Source files
------------

// File: rtl/idex_hazard_stage_if.sv
// Bundle of ID-side inputs and IDEX-side outputs for the ID/EX hazard stage.
interface idex_hazard_stage_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
);
  // ID-side (decoded instruction entering the stage)
  logic              id_valid;
  logic [4:0]        IFID_Reg_Rs;
  logic [4:0]        IFID_Reg_Rt;
  logic [4:0]        id_rd;
  logic [DATA_W-1:0] id_data1;
  logic [DATA_W-1:0] id_data2;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc_plus4;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_MemRead;
  logic              id_RegWrite;
  logic              ex_flush;
  logic              mem_busy;

  // EX-side (registered fields) and fetch stall controls
  logic [4:0]        IDEX_Reg_Rs;
  logic [4:0]        IDEX_Reg_Rt;
  logic [4:0]        IDEX_Reg_Rd;
  logic [DATA_W-1:0] IDEX_Data1;
  logic [DATA_W-1:0] IDEX_Data2;
  logic [DATA_W-1:0] IDEX_Imm;
  logic [DATA_W-1:0] IDEX_PC_plus4;
  logic [CTRL_W-1:0] IDEX_Ctrl;
  logic              IDEX_MemRead;
  logic              IDEX_RegWrite;
  logic              IDEX_Valid;
  logic              PC_Write;
  logic              IFID_Write;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [1:0]        state;

  modport master (
    output id_valid, IFID_Reg_Rs, IFID_Reg_Rt, id_rd, id_data1, id_data2,
           id_imm, id_pc_plus4, id_ctrl, id_MemRead, id_RegWrite,
           ex_flush, mem_busy,
    input  IDEX_Reg_Rs, IDEX_Reg_Rt, IDEX_Reg_Rd, IDEX_Data1, IDEX_Data2,
           IDEX_Imm, IDEX_PC_plus4, IDEX_Ctrl, IDEX_MemRead, IDEX_RegWrite,
           IDEX_Valid, PC_Write, IFID_Write, bubble_cnt, state
  );

  modport slave (
    input  id_valid, IFID_Reg_Rs, IFID_Reg_Rt, id_rd, id_data1, id_data2,
           id_imm, id_pc_plus4, id_ctrl, id_MemRead, id_RegWrite,
           ex_flush, mem_busy,
    output IDEX_Reg_Rs, IDEX_Reg_Rt, IDEX_Reg_Rd, IDEX_Data1, IDEX_Data2,
           IDEX_Imm, IDEX_PC_plus4, IDEX_Ctrl, IDEX_MemRead, IDEX_RegWrite,
           IDEX_Valid, PC_Write, IFID_Write, bubble_cnt, state
  );
endinterface

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush on taken branch/jump, freeze on data-memory busy, and a saturating
// count of inserted load-use bubbles.
module idex_hazard_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input logic                clk,
  input logic                reset,
  idex_hazard_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_BUBBLE = 2'b01,
    ST_HOLD   = 2'b10
  } state_t;

  state_t state_p1, state_nxt;

  logic [4:0]        rs_p1, rt_p1, rd_p1;
  logic [DATA_W-1:0] data1_p1, data2_p1, imm_p1, pc_plus4_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic              mem_read_p1, reg_write_p1, vld_p1;
  logic [CNT_W-1:0]  bubble_cnt_p1;

  logic hazard;
  logic do_hold, do_bubble, do_count, fetch_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Load-use: the instruction in EX is a load whose target is read by ID.
  assign hazard = bus.id_valid & vld_p1 & mem_read_p1 & (rd_p1 != 5'd0)
                & ((rd_p1 == bus.IFID_Reg_Rs) | (rd_p1 == bus.IFID_Reg_Rt));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_p1 <= ST_RUN;
    else        state_p1 <= state_nxt;
  end

  // Next state follows edge priority: flush, busy, hazard, normal load
  always_comb begin
    state_nxt = ST_RUN;
    if (bus.ex_flush)      state_nxt = ST_RUN;
    else if (bus.mem_busy) state_nxt = ST_HOLD;
    else if (hazard)       state_nxt = ST_BUBBLE;
  end

  // Stage actions and fetch stall; a flush never stalls fetch by itself
  always_comb begin
    do_hold   = 1'b0;
    do_bubble = 1'b0;
    do_count  = 1'b0;
    if (bus.ex_flush) begin
      do_bubble = 1'b1;
    end else if (bus.mem_busy) begin
      do_hold = 1'b1;
    end else if (hazard) begin
      do_bubble = 1'b1;
      do_count  = 1'b1;
    end
    fetch_en = ~(bus.mem_busy | (hazard & ~bus.ex_flush));
  end

  // ---- ID -> EX stage boundary ----
  // Pipeline register: hold on busy, zeroed bubble on flush/hazard, else capture ID
  always_ff @(posedge clk) begin
    if (!reset) begin
      rs_p1         <= '0;
      rt_p1         <= '0;
      rd_p1         <= '0;
      data1_p1      <= '0;
      data2_p1      <= '0;
      imm_p1        <= '0;
      pc_plus4_p1   <= '0;
      ctrl_p1       <= '0;
      mem_read_p1   <= 1'b0;
      reg_write_p1  <= 1'b0;
      vld_p1        <= 1'b0;
      bubble_cnt_p1 <= '0;
    end else if (do_hold) begin
      rs_p1 <= rs_p1;
    end else if (do_bubble) begin
      rs_p1        <= '0;
      rt_p1        <= '0;
      rd_p1        <= '0;
      data1_p1     <= '0;
      data2_p1     <= '0;
      imm_p1       <= '0;
      pc_plus4_p1  <= '0;
      ctrl_p1      <= '0;
      mem_read_p1  <= 1'b0;
      reg_write_p1 <= 1'b0;
      vld_p1       <= 1'b0;
      if (do_count) bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end else begin
      rs_p1        <= bus.IFID_Reg_Rs;
      rt_p1        <= bus.IFID_Reg_Rt;
      rd_p1        <= bus.id_rd;
      data1_p1     <= bus.id_data1;
      data2_p1     <= bus.id_data2;
      imm_p1       <= bus.id_imm;
      pc_plus4_p1  <= bus.id_pc_plus4;
      ctrl_p1      <= bus.id_ctrl;
      mem_read_p1  <= bus.id_MemRead;
      reg_write_p1 <= bus.id_RegWrite;
      vld_p1       <= bus.id_valid;
    end
  end

  assign bus.IDEX_Reg_Rs   = rs_p1;
  assign bus.IDEX_Reg_Rt   = rt_p1;
  assign bus.IDEX_Reg_Rd   = rd_p1;
  assign bus.IDEX_Data1    = data1_p1;
  assign bus.IDEX_Data2    = data2_p1;
  assign bus.IDEX_Imm      = imm_p1;
  assign bus.IDEX_PC_plus4 = pc_plus4_p1;
  assign bus.IDEX_Ctrl     = ctrl_p1;
  assign bus.IDEX_MemRead  = mem_read_p1;
  assign bus.IDEX_RegWrite = reg_write_p1;
  assign bus.IDEX_Valid    = vld_p1;
  assign bus.PC_Write      = fetch_en;
  assign bus.IFID_Write    = fetch_en;
  assign bus.bubble_cnt    = bubble_cnt_p1;
  assign bus.state         = state_p1;

endmodule
